// File: rtl/cpu_pkg.sv
// Shared state encoding and PC constants for the program-counter sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Priority next-PC mux (jr > jump > branch > sequential) with word alignment.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic        i_en_redirect,
    input  logic [31:0] i_pc_cur,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_pc_next,
    output logic        o_redirect
);

    logic [31:0] w_seq_pc;

    assign w_seq_pc = i_pc_cur + PC_INC;

    always_comb begin
        o_pc_next  = align_word(w_seq_pc);
        o_redirect = 1'b0;
        // Redirects are masked outside the fetch states so HALT resume always skips ahead.
        if (i_en_redirect) begin
            if (i_jr) begin
                o_pc_next  = align_word(i_jr_target);
                o_redirect = 1'b1;
            end else if (i_jump) begin
                o_pc_next  = align_word(i_jump_target);
                o_redirect = 1'b1;
            end else if (i_br_taken) begin
                o_pc_next  = align_word(i_br_target);
                o_redirect = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencing FSM: boot, fetch/stall/halt control, imem timeout and debug statistics.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32,
    parameter int          WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_cur,
    input  logic             imem_ready,
    input  logic             stall_req,
    input  logic             halt,
    input  logic             go,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic             pc_en,
    output logic [31:0]      pc_next,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    state_t             r_state;
    logic [WCW-1:0]     r_wait;
    logic               r_err;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_redirect_cnt;

    state_t             w_state_nxt;
    logic [WCW-1:0]     w_wait_nxt;
    logic [WCW-1:0]     w_wait_inc;
    logic               w_err_set;
    logic               w_pc_en;
    logic [31:0]        w_pc_next;
    logic [31:0]        w_sel_pc;
    logic               w_sel_redirect;
    logic               w_fetch_state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_fetch_state = (r_state == ST_RUN) || (r_state == ST_WAIT);
    assign w_wait_inc    = r_wait + 1'b1;

    next_pc_sel u_sel (
        .i_en_redirect (w_fetch_state),
        .i_pc_cur      (pc_cur),
        .i_jr          (jr),
        .i_jr_target   (jr_target),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .i_br_taken    (br_taken),
        .i_br_target   (br_target),
        .o_pc_next     (w_sel_pc),
        .o_redirect    (w_sel_redirect)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_err_set   = 1'b0;
        w_pc_en     = 1'b0;
        w_pc_next   = w_sel_pc;
        unique case (r_state)
            ST_BOOT: begin
                w_pc_en     = 1'b1;
                w_pc_next   = RESET_PC;
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
                if (!imem_ready) begin
                    if (r_state == ST_RUN) begin
                        w_state_nxt = ST_WAIT;
                        w_wait_nxt  = WCW'(1);
                    end else begin
                        w_wait_nxt = w_wait_inc;
                        if (w_wait_inc == WCW'(WAIT_MAX)) begin
                            w_state_nxt = ST_ERROR;
                            w_err_set   = 1'b1;
                        end
                    end
                end else begin
                    // A ready WAIT cycle is handled exactly like RUN: no bubble.
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                    if (stall_req) begin
                        w_pc_en = 1'b0;
                    end else if (halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_en = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (go) begin
                    w_pc_en     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_BOOT;
            r_wait         <= '0;
            r_err          <= 1'b0;
            r_cycle_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_err   <= r_err | w_err_set;
            if (w_fetch_state) begin
                r_cycle_cnt <= sat_inc(r_cycle_cnt);
            end
            if (w_pc_en && w_sel_redirect) begin
                r_redirect_cnt <= sat_inc(r_redirect_cnt);
            end
        end
    end

    assign pc_en        = w_pc_en & rst;
    assign pc_next      = w_pc_next;
    assign state        = r_state;
    assign err          = r_err;
    assign cycle_cnt    = r_cycle_cnt;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer with a cycle-level behavioural reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RPC  = 32'h0000_3000;
    localparam int          WMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        imem_ready, stall_req, halt, go, br_taken, jump, jr;
    logic [31:0] br_target, jump_target, jr_target;

    logic        pc_en, pc_en_s;
    logic [31:0] pc_next, pc_next_s;
    logic [2:0]  state, state_s;
    logic        err, err_s;
    logic [31:0] cycle_cnt, redirect_cnt;
    logic [3:0]  cyc_s, red_s;

    pc_sequencer u_dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .imem_ready(imem_ready),
        .stall_req(stall_req), .halt(halt), .go(go),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .pc_en(pc_en), .pc_next(pc_next), .state(state), .err(err),
        .cycle_cnt(cycle_cnt), .redirect_cnt(redirect_cnt)
    );

    pc_sequencer #(.CNT_W(4)) u_dut_s (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .imem_ready(imem_ready),
        .stall_req(stall_req), .halt(halt), .go(go),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .pc_en(pc_en_s), .pc_next(pc_next_s), .state(state_s), .err(err_s),
        .cycle_cnt(cyc_s), .redirect_cnt(red_s)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: mode numbers are the debug codes 0..4 (boot, run, wait, halt, error)
    int          m_st, m_wait;
    bit          m_err;
    longint      m_cyc, m_red;
    bit          e_en, e_redir;
    logic [31:0] e_nx;
    int          e_nst, e_wait;
    bit          pc_upd;
    logic [31:0] pc_pend;

    function automatic logic [31:0] sat15(input longint v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    task automatic model_eval();
        logic [31:0] seq;
        seq     = (pc_cur + 32'd4) & 32'hFFFF_FFFC;
        e_en    = 0;
        e_redir = 0;
        e_nx    = seq;
        e_nst   = m_st;
        e_wait  = m_wait;
        if (m_st == 0) begin
            e_en  = 1;
            e_nx  = RPC;
            e_nst = 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (!imem_ready) begin
                e_wait = m_wait + 1;
                e_nst  = (e_wait >= WMAX) ? 4 : 2;
            end else begin
                e_wait = 0;
                e_nst  = 1;
                if (stall_req) begin
                    e_en = 0;
                end else if (halt) begin
                    e_nst = 3;
                end else begin
                    e_en = 1;
                    if (jr) begin
                        e_nx = jr_target & 32'hFFFF_FFFC; e_redir = 1;
                    end else if (jump) begin
                        e_nx = jump_target & 32'hFFFF_FFFC; e_redir = 1;
                    end else if (br_taken) begin
                        e_nx = br_target & 32'hFFFF_FFFC; e_redir = 1;
                    end
                end
            end
        end else if (m_st == 3) begin
            if (go) begin
                e_en  = 1;
                e_nst = 1;
            end
        end
    endtask

    task automatic eval_check();
        #1;
        model_eval();
        check_val("pc_en", pc_en, e_en);
        if (e_en) check_val("pc_next", pc_next, e_nx);
        check_val("state", state, m_st);
        check_val("err", err, m_err);
        check_val("cycle_cnt", cycle_cnt, m_cyc[31:0]);
        check_val("redirect_cnt", redirect_cnt, m_red[31:0]);
        check_val("sat_cycle_cnt", cyc_s, sat15(m_cyc));
        check_val("sat_redirect_cnt", red_s, sat15(m_red));
        check_val("sat_pc_en", pc_en_s, e_en);
    endtask

    task automatic commit();
        @(posedge clk);
        if (m_st == 1 || m_st == 2) m_cyc++;
        if (e_en && e_redir) m_red++;
        if (e_nst == 4) m_err = 1;
        m_st    = e_nst;
        m_wait  = e_wait;
        pc_upd  = e_en;
        pc_pend = e_nx;
    endtask

    task automatic quiet();
        imem_ready = 1; stall_req = 0; halt = 0; go = 0;
        br_taken = 0; jump = 0; jr = 0;
        br_target = 0; jump_target = 0; jr_target = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        if (pc_upd) pc_cur = pc_pend;
    endtask

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_err = 0; m_cyc = 0; m_red = 0; pc_upd = 0;
    endtask

    // Reset lands mid-cycle so its effect must be visible before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0;
        #1;
        check_val("rst_state", state, 3'd0);
        check_val("rst_pc_en", pc_en, 1'b0);
        check_val("rst_pc_next", pc_next, RPC);
        check_val("rst_err", err, 1'b0);
        check_val("rst_cycle_cnt", cycle_cnt, 32'd0);
        check_val("rst_redirect_cnt", redirect_cnt, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst = 1;
    endtask

    task automatic run_cycle();
        eval_check();
        commit();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint      saved;
        int          burst;
        int          err_dwell;
        rst    = 0;
        pc_cur = 32'd0;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1;

        // Boot and sequential fetch
        next_cycle(); eval_check();
        check_val("t1_boot_pc", pc_next, 32'h3000);
        commit();
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); eval_check();
            check_val("t1_seq_pc", pc_next, 32'h3000 + 32'(4 * k));
            commit();
        end
        next_cycle(); eval_check();
        check_val("t1_cycle_cnt", cycle_cnt, 32'd3);
        commit();

        // Simultaneous redirects: jr wins and is word-aligned
        next_cycle();
        pc_cur = 32'h3010;
        jr = 1; jr_target = 32'h4001; jump = 1; jump_target = 32'h5000;
        br_taken = 1; br_target = 32'h6000;
        saved = m_red;
        eval_check();
        check_val("t2_pc_next", pc_next, 32'h4000);
        check_val("t2_pc_en", pc_en, 1'b1);
        commit();
        next_cycle(); quiet(); eval_check();
        check_val("t2_redirect_cnt", redirect_cnt, 32'(saved + 1));
        commit();

        // Stall, halt with ignored jump, resume
        for (int k = 0; k < 2; k++) begin
            next_cycle(); stall_req = 1; eval_check();
            check_val("t3_stall_pc_en", pc_en, 1'b0);
            commit();
        end
        next_cycle(); stall_req = 0; halt = 1; jump = 1; jump_target = 32'h5000;
        saved = m_red;
        eval_check();
        check_val("t3_halt_pc_en", pc_en, 1'b0);
        commit();
        next_cycle(); quiet(); eval_check();
        check_val("t3_halt_state", state, 3'd3);
        check_val("t3_halt_redirect_cnt", redirect_cnt, 32'(saved));
        commit();
        next_cycle(); pc_cur = 32'h3020; go = 1; jr = 1; jr_target = 32'h7000;
        eval_check();
        check_val("t3_go_pc_next", pc_next, 32'h3024);
        commit();
        next_cycle(); quiet(); eval_check();
        check_val("t3_resume_state", state, 3'd1);
        commit();

        // Short imem wait, then a branch in the ready cycle
        for (int k = 0; k < 3; k++) begin
            next_cycle(); imem_ready = 0; eval_check(); commit();
        end
        next_cycle(); imem_ready = 1; br_taken = 1; br_target = 32'h3100;
        eval_check();
        check_val("t4_wait_state", state, 3'd2);
        check_val("t4_ready_pc_en", pc_en, 1'b1);
        check_val("t4_ready_pc_next", pc_next, 32'h3100);
        commit();
        next_cycle(); quiet(); eval_check();
        check_val("t4_back_run", state, 3'd1);
        check_val("t4_no_err", err, 1'b0);
        commit();

        // Memory timeout into ERROR
        for (int k = 0; k < WMAX; k++) begin
            next_cycle(); imem_ready = 0; eval_check(); commit();
        end
        next_cycle(); eval_check();
        check_val("t5_err_state", state, 3'd4);
        check_val("t5_err_flag", err, 1'b1);
        commit();
        for (int k = 0; k < 3; k++) begin
            next_cycle(); quiet(); eval_check();
            check_val("t5_err_pc_en", pc_en, 1'b0);
            commit();
        end
        do_reset();

        // Address wrap, then asynchronous reset mid-cycle
        next_cycle(); quiet(); run_cycle();
        next_cycle(); pc_cur = 32'hFFFF_FFFC; eval_check();
        check_val("t6_wrap", pc_next, 32'h0000_0000);
        commit();
        do_reset();

        // Randomized traffic with occasional timeouts and resets
        burst     = 0;
        err_dwell = 0;
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            if (burst == 0 && $urandom_range(0, 99) < 2) burst = $urandom_range(10, 20);
            imem_ready  = (burst > 0) ? 1'b0 : ($urandom_range(0, 99) < 80);
            if (burst > 0) burst--;
            stall_req   = ($urandom_range(0, 99) < 15);
            halt        = ($urandom_range(0, 99) < 8);
            go          = ($urandom_range(0, 99) < 30);
            br_taken    = ($urandom_range(0, 99) < 30);
            jump        = ($urandom_range(0, 99) < 15);
            jr          = ($urandom_range(0, 99) < 10);
            br_target   = $urandom;
            jump_target = $urandom;
            jr_target   = $urandom;
            if ($urandom_range(0, 99) < 10) pc_cur = $urandom;
            run_cycle();
            err_dwell = (m_st == 4) ? err_dwell + 1 : 0;
            if (err_dwell > 4 || $urandom_range(0, 999) < 8) begin
                do_reset();
                err_dwell = 0;
                burst     = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
